// File: rtl/alu_share_arbiter_pkg.sv
// Shared definitions for the ALU share arbiter: FSM state encoding,
// requester ids and the ALUop encodings common to ALUdec and the ALU.
package alu_share_arbiter_pkg;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_EXEC = 2'd1,
        S_RESP = 2'd2
    } state_t;

    localparam logic REQ_PIPE = 1'b0;   // main pipeline
    localparam logic REQ_AUX  = 1'b1;   // multi-cycle helper unit

    // Width of the ALU latency counter; ALU_LAT must fit in 1..15.
    localparam int CNT_W = 4;

    // ALUop encodings shared with ALUdec / ALU.
    localparam logic [3:0] ALU_ADD = 4'd0;
    localparam logic [3:0] ALU_SUB = 4'd1;
    localparam logic [3:0] ALU_AND = 4'd2;
    localparam logic [3:0] ALU_OR  = 4'd3;
    localparam logic [3:0] ALU_XOR = 4'd4;
    localparam logic [3:0] ALU_SLL = 4'd5;
    localparam logic [3:0] ALU_SRL = 4'd6;
    localparam logic [3:0] ALU_SLT = 4'd7;

endpackage

// File: rtl/alu_share_arbiter_if.sv
// Bus bundle for the ALU share arbiter: two request channels, the ALU
// operand/result path and the response channel.
//
// Handshake rule for every channel: a transfer happens on the rising clk
// edge where valid and ready are both high. The source holds valid and its
// payload stable until that edge; ready may depend on valid, never on payload.
//
// Modports:
//   slave  - the arbiter itself
//   master - the environment (requesters, ALU and result consumer)
interface alu_share_arbiter_if #(
    parameter int WIDTH = 32,
    parameter int OPW   = 4
) ();
    logic             req0_valid;
    logic             req0_ready;
    logic [WIDTH-1:0] req0_a;
    logic [WIDTH-1:0] req0_b;
    logic [OPW-1:0]   req0_op;

    logic             req1_valid;
    logic             req1_ready;
    logic [WIDTH-1:0] req1_a;
    logic [WIDTH-1:0] req1_b;
    logic [OPW-1:0]   req1_op;

    logic [WIDTH-1:0] alu_a;
    logic [WIDTH-1:0] alu_b;
    logic [OPW-1:0]   alu_op;
    logic [WIDTH-1:0] alu_out;

    logic             resp_valid;
    logic             resp_ready;
    logic             resp_id;
    logic [WIDTH-1:0] resp_data;

    modport slave (
        input  req0_valid, req0_a, req0_b, req0_op,
        output req0_ready,
        input  req1_valid, req1_a, req1_b, req1_op,
        output req1_ready,
        output alu_a, alu_b, alu_op,
        input  alu_out,
        output resp_valid, resp_id, resp_data,
        input  resp_ready
    );

    modport master (
        output req0_valid, req0_a, req0_b, req0_op,
        input  req0_ready,
        output req1_valid, req1_a, req1_b, req1_op,
        input  req1_ready,
        input  alu_a, alu_b, alu_op,
        output alu_out,
        input  resp_valid, resp_id, resp_data,
        output resp_ready
    );
endinterface

// File: rtl/alu_share_arbiter_rr_arb2.sv
// Two-way round-robin grant, purely combinational.
// Ports:
//   valid[1:0]  - request lines (bit N = requester N)
//   last_grant  - id of the requester served most recently (held by parent)
//   en          - arbiter may grant this cycle
//   grant[1:0]  - one-hot grant, all zero when en is low or nobody requests
module alu_share_arbiter_rr_arb2
    import alu_share_arbiter_pkg::*;
(
    input  logic [1:0] valid,
    input  logic       last_grant,
    input  logic       en,
    output logic [1:0] grant
);
    always_comb begin
        grant = 2'b00;
        if (en) begin
            case (valid)
                2'b01:   grant = 2'b01;
                2'b10:   grant = 2'b10;
                // Tie: the requester that was not served last wins.
                2'b11:   grant = (last_grant == REQ_PIPE) ? 2'b10 : 2'b01;
                default: grant = 2'b00;
            endcase
        end
    end
endmodule

// File: rtl/alu_share_arbiter.sv
// Shares one external ALU between two requesters. Accepts one operation at
// a time (round-robin on ties), registers operands and ALUop, holds them on
// the ALU for ALU_LAT cycles, then returns the ALU result tagged with the
// requester id. At most one operation is in flight.
// Ports:
//   clk, reset  - clock, synchronous active-high reset
//   bus         - request / ALU / response bundle (slave side)
//   dbg_state   - current FSM state, for observation only
module alu_share_arbiter
    import alu_share_arbiter_pkg::*;
#(
    parameter int WIDTH   = 32,
    parameter int OPW     = 4,
    parameter int ALU_LAT = 1
) (
    input  logic                clk,
    input  logic                reset,
    alu_share_arbiter_if.slave  bus,
    output state_t              dbg_state
);
    if (ALU_LAT < 1 || ALU_LAT > 15) begin : g_lat_check
        $error("alu_share_arbiter: ALU_LAT=%0d outside 1..15", ALU_LAT);
    end

    localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(ALU_LAT - 1);

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q;
    logic             last_grant_q;
    logic             id_q;
    logic [WIDTH-1:0] a_q, b_q;
    logic [OPW-1:0]   op_q;
    logic             resp_valid_q;
    logic             resp_id_q;
    logic [WIDTH-1:0] resp_data_q;

    logic             can_accept;
    logic [1:0]       grant;
    logic             accept;
    logic             acc_id;
    logic             exec_done;
    logic             resp_fire;

    // A new op may enter while idle, or in the same cycle the pending result
    // leaves (back-to-back). Readies are forced low while reset is high.
    assign can_accept = !reset &&
                        ((state_q == S_IDLE) || (state_q == S_RESP && bus.resp_ready));

    alu_share_arbiter_rr_arb2 u_arb (
        .valid      ({bus.req1_valid, bus.req0_valid}),
        .last_grant (last_grant_q),
        .en         (can_accept),
        .grant      (grant)
    );

    // grant is non-zero only for a valid requester, so it doubles as accept.
    assign accept     = |grant;
    assign acc_id     = grant[1];
    assign exec_done  = (state_q == S_EXEC) && (cnt_q == '0);
    assign resp_fire  = resp_valid_q && bus.resp_ready;

    always_ff @(posedge clk) begin
        if (reset) state_q <= S_IDLE;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: if (accept) state_d = S_EXEC;
            S_EXEC: if (cnt_q == '0) state_d = S_RESP;
            S_RESP: if (bus.resp_ready) state_d = accept ? S_EXEC : S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q        <= '0;
            last_grant_q <= REQ_AUX;
            id_q         <= REQ_PIPE;
            a_q          <= '0;
            b_q          <= '0;
            op_q         <= '0;
            resp_valid_q <= 1'b0;
            resp_id_q    <= REQ_PIPE;
            resp_data_q  <= '0;
        end else begin
            if (accept) begin
                a_q          <= acc_id ? bus.req1_a  : bus.req0_a;
                b_q          <= acc_id ? bus.req1_b  : bus.req0_b;
                op_q         <= acc_id ? bus.req1_op : bus.req0_op;
                id_q         <= acc_id;
                last_grant_q <= acc_id;
                cnt_q        <= CNT_INIT;
            end else if (state_q == S_EXEC && cnt_q != '0) begin
                cnt_q <= cnt_q - 1'b1;
            end

            // The result register is written only on leaving EXEC, so a
            // stalled result in RESP can never be overwritten.
            if (exec_done) begin
                resp_data_q  <= bus.alu_out;
                resp_id_q    <= id_q;
                resp_valid_q <= 1'b1;
            end else if (resp_fire) begin
                resp_valid_q <= 1'b0;
            end
        end
    end

    assign bus.req0_ready = grant[0];
    assign bus.req1_ready = grant[1];
    assign bus.alu_a      = a_q;
    assign bus.alu_b      = b_q;
    assign bus.alu_op     = op_q;
    assign bus.resp_valid = resp_valid_q;
    assign bus.resp_id    = resp_id_q;
    assign bus.resp_data  = resp_data_q;
    assign dbg_state      = state_q;
endmodule
